// File: rtl/counter_mode_sequencer.sv
// Command sequencer for the 2-bit mode-selectable counter: queues {mode, steps} commands and issues enables.
// Define COUNTER_SEQ_CHECK_EN to add the sticky chk_err output that cross-checks q_fb against a shadow count.
module counter_mode_sequencer #(
    parameter int STEP_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_mode,
    input  logic [STEP_W-1:0] cmd_steps,
    input  logic              abort,
    input  logic [1:0]        q_fb,
    output logic              s1,
    output logic              s0,
    output logic              cnt_en,
    output logic              cnt_clr,
    output logic              busy,
    output logic              done,
    output logic              aborted
`ifdef COUNTER_SEQ_CHECK_EN
    ,
    output logic              chk_err
`endif
);

    localparam int          AW         = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t            state;
    state_t            next_state;
    logic [1:0]        fifo_mode  [FIFO_DEPTH];
    logic [STEP_W-1:0] fifo_steps [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              empty;
    logic              full;
    logic              push;
    logic              pop;
    logic              live;
    logic [1:0]        mode_q;
    logic [STEP_W-1:0] steps_q;
    logic              aborted_q;

    assign empty     = (count == '0);
    assign full      = (count == FULL_COUNT);
    assign cmd_ready = live && !full && !abort;
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state == IDLE) && !empty && !abort;

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mode[wr_ptr]  <= cmd_mode;
            fifo_steps[wr_ptr] <= cmd_steps;
        end
    end

    // Abort flushes the queue by collapsing the pointers; stored entries become unreachable.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (abort) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Holds cmd_ready low until the first clock edge after reset release.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) live <= 1'b0;
        else          live <= 1'b1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (abort) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    if (!empty) next_state = LOAD;
                LOAD:    next_state = (steps_q != '0) ? RUN : DONE;
                RUN:     if (steps_q == STEP_W'(1)) next_state = DONE;
                DONE:    next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mode_q    <= 2'b00;
            steps_q   <= '0;
            aborted_q <= 1'b0;
        end else begin
            aborted_q <= abort;
            if (pop) begin
                mode_q  <= fifo_mode[rd_ptr];
                steps_q <= fifo_steps[rd_ptr];
            end else if (state == RUN) begin
                steps_q <= steps_q - 1'b1;
            end
        end
    end

    // A mod-3 mode cannot represent 11, so the counter is cleared on entry in that case.
    always_comb begin
        cnt_en  = 1'b0;
        cnt_clr = 1'b0;
        done    = 1'b0;
        busy    = (state != IDLE) || !empty;
        case (state)
            LOAD:    cnt_clr = mode_q[1] && (q_fb == 2'b11);
            RUN:     cnt_en  = 1'b1;
            DONE:    done    = 1'b1;
            default: ;
        endcase
    end

    assign s1      = mode_q[1];
    assign s0      = mode_q[0];
    assign aborted = aborted_q;

`ifdef COUNTER_SEQ_CHECK_EN
    logic [1:0] exp_q;
    logic       first_q;
    logic       chk_q;

    function automatic logic [1:0] advance(input logic [1:0] q, input logic [1:0] mode);
        logic [1:0] r;
        case (mode)
            2'b00:   r = q + 2'd1;
            2'b01:   r = q - 2'd1;
            2'b10:   r = (q == 2'b10) ? 2'b00 : q + 2'd1;
            default: r = (q == 2'b00) ? 2'b10 : q - 2'd1;
        endcase
        return r;
    endfunction

    // The first RUN cycle is skipped because the clear from LOAD is only just landing.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            exp_q   <= 2'b00;
            first_q <= 1'b0;
            chk_q   <= 1'b0;
        end else begin
            first_q <= (state == LOAD);
            if (state == LOAD)
                exp_q <= cnt_clr ? 2'b00 : q_fb;
            else if (cnt_en)
                exp_q <= advance(exp_q, mode_q);
            if ((((state == RUN) && !first_q) || (state == DONE)) && (q_fb != exp_q))
                chk_q <= 1'b1;
        end
    end

    assign chk_err = chk_q;
`endif

endmodule

// File: tb/tb_counter_mode_sequencer.sv
// Scoreboard bench for counter_mode_sequencer: a timeline model predicts each command's LOAD/DONE cycles.
// Also models the attached counter so q_fb is realistic; optionally checks chk_err under COUNTER_SEQ_CHECK_EN.
module tb_counter_mode_sequencer;

    localparam int STEP_W     = 8;
    localparam int FIFO_DEPTH = 4;

    logic              clock     = 1'b0;
    logic              reset_n   = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              abort     = 1'b0;
    logic [1:0]        cmd_mode  = 2'b00;
    logic [STEP_W-1:0] cmd_steps = '0;
    logic [1:0]        q_fb;
    logic              cmd_ready, s1, s0, cnt_en, cnt_clr, busy, done, aborted;
`ifdef COUNTER_SEQ_CHECK_EN
    logic              chk_err;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    counter_mode_sequencer #(.STEP_W(STEP_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clock(clock), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_mode(cmd_mode), .cmd_steps(cmd_steps), .abort(abort), .q_fb(q_fb),
        .s1(s1), .s0(s0), .cnt_en(cnt_en), .cnt_clr(cnt_clr), .busy(busy),
        .done(done), .aborted(aborted)
`ifdef COUNTER_SEQ_CHECK_EN
        , .chk_err(chk_err)
`endif
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [1:0] nextCount(input logic [1:0] q, input logic [1:0] mode);
        int m;
        int v;
        m = mode[1] ? 3 : 4;
        v = mode[0] ? (int'(q) + m - 1) % m : (int'(q) + 1) % m;
        return 2'(v);
    endfunction

    // The counter instance the sequencer drives.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n)     q_fb <= 2'b00;
        else if (cnt_clr) q_fb <= 2'b00;
        else if (cnt_en)  q_fb <= nextCount(q_fb, {s1, s0});
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s cycle=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    typedef struct {
        int         acc;
        int         load;
        int         fin;
        logic [1:0] mode;
        int         steps;
    } ent_t;

    ent_t       sb[$];
    ent_t       ent;
    logic [1:0] held_mode  = 2'b00;
    int         free_at    = 0;
    int         ab_cyc     = -10;
    int         last_reset = 0;
    int         en_count   = 0;
    int         occ;
    logic       busy_e, ready_e, en_e, done_e, clr_e, head_loaded;
    logic [1:0] mode_e;

    // Monitor: compares every cycle against the timeline, pops on done, flushes on abort, pushes on accept.
    initial forever begin
        @(negedge clock);
        if (!reset_n) begin
            checkOutput("reset_outputs",
                        32'({cmd_ready, s1, s0, cnt_en, cnt_clr, busy, done, aborted}), 32'd0);
            sb.delete();
            held_mode  = 2'b00;
            free_at    = 0;
            ab_cyc     = -10;
            last_reset = cyc;
            en_count   = 0;
        end else begin
            occ    = 0;
            busy_e = 1'b0;
            foreach (sb[i]) begin
                if (sb[i].acc + 1 <= cyc) begin
                    busy_e = 1'b1;
                    if (cyc < sb[i].load) occ++;
                end
            end
            ready_e     = (cyc > last_reset) && (occ < FIFO_DEPTH) && !abort;
            head_loaded = (sb.size() > 0) && (sb[0].load <= cyc);
            en_e        = head_loaded && (cyc > sb[0].load) && (cyc < sb[0].fin);
            done_e      = head_loaded && (cyc == sb[0].fin);
            clr_e       = head_loaded && (cyc == sb[0].load) && sb[0].mode[1] && (q_fb == 2'b11);
            mode_e      = head_loaded ? sb[0].mode : held_mode;

            checkOutput("cmd_ready", 32'(cmd_ready), 32'(ready_e));
            checkOutput("busy",      32'(busy),      32'(busy_e));
            checkOutput("cnt_en",    32'(cnt_en),    32'(en_e));
            checkOutput("cnt_clr",   32'(cnt_clr),   32'(clr_e));
            checkOutput("done",      32'(done),      32'(done_e));
            checkOutput("mode",      32'({s1, s0}),  32'(mode_e));
            checkOutput("aborted",   32'(aborted),   32'(cyc == ab_cyc + 1));
`ifdef COUNTER_SEQ_CHECK_EN
            checkOutput("chk_err",   32'(chk_err),   32'd0);
`endif
            if (cnt_en) en_count++;
            if ((done || done_e) && sb.size() > 0) begin
                ent = sb.pop_front();
                checkOutput("done_steps", 32'(en_count), 32'(ent.steps));
                held_mode = ent.mode;
                en_count  = 0;
            end
            if (abort) begin
                if (sb.size() > 0 && sb[0].load <= cyc) held_mode = sb[0].mode;
                sb.delete();
                ab_cyc   = cyc;
                free_at  = 0;
                en_count = 0;
            end
            if (cmd_valid && ready_e) begin
                ent.acc   = cyc;
                ent.load  = (cyc + 2 > free_at) ? cyc + 2 : free_at;
                ent.fin   = ent.load + 1 + int'(cmd_steps);
                ent.mode  = cmd_mode;
                ent.steps = int'(cmd_steps);
                sb.push_back(ent);
                free_at = ent.fin + 2;
            end
        end
    end

    task automatic syncDrive();
        @(posedge clock);
        #1;
    endtask

    // Offers one command and returns in the cycle after the accepting edge.
    task automatic applyStimulus(input logic [1:0] mode, input int steps, output int waited);
        logic acc;
        acc       = 1'b0;
        waited    = 0;
        cmd_valid = 1'b1;
        cmd_mode  = mode;
        cmd_steps = STEP_W'(steps);
        for (int n = 0; n < 300; n++) begin
            @(negedge clock);
            acc = cmd_ready;
            @(posedge clock);
            #1;
            if (acc) break;
            waited++;
        end
        cmd_valid = 1'b0;
        if (!acc) checkOutput("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic waitDone(output logic ok);
        ok = 1'b0;
        for (int n = 0; n < 600; n++) begin
            @(negedge clock);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) checkOutput("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic waitIdle();
        logic ok;
        ok = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clock);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) checkOutput("idle_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int   w;
        logic ok;
        logic seen;

        #12 reset_n = 1'b1;
        syncDrive();

        applyStimulus(2'b01, 3, w);
        waitDone(ok);
        checkOutput("m01_final_q", 32'(q_fb), 32'd1);
        checkOutput("m01_mode", 32'({s1, s0}), 32'd1);

        syncDrive();
        applyStimulus(2'b00, 2, w);
        waitDone(ok);
        checkOutput("m00_final_q", 32'(q_fb), 32'd3);

        syncDrive();
        applyStimulus(2'b10, 4, w);
        waitDone(ok);
        checkOutput("m10_final_q", 32'(q_fb), 32'd1);

        syncDrive();
        applyStimulus(2'b11, 0, w);
        waitDone(ok);
        checkOutput("m11_zero_mode", 32'({s1, s0}), 32'd3);

        // Long command keeps the block busy so the queue fills behind it.
        syncDrive();
        applyStimulus(2'b00, 10, w);
        for (int i = 0; i < 5; i++) applyStimulus(2'(i), 3, w);
        checkOutput("fifth_waited", 32'(w > 0), 32'd1);
        waitIdle();

        syncDrive();
        applyStimulus(2'b00, 255, w);
        waitDone(ok);

        syncDrive();
        applyStimulus(2'b00, 8, w);
        applyStimulus(2'b01, 2, w);
        applyStimulus(2'b10, 2, w);
        seen = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clock);
            if (cnt_en) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput("abort_run_seen", 32'(seen), 32'd1);
        syncDrive();
        abort = 1'b1;
        syncDrive();
        abort = 1'b0;
        @(negedge clock);
        checkOutput("abort_en_low", 32'(cnt_en), 32'd0);
        checkOutput("abort_pulse", 32'(aborted), 32'd1);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        @(negedge clock);
        checkOutput("abort_pulse_end", 32'(aborted), 32'd0);
        syncDrive();
        applyStimulus(2'b01, 1, w);
        waitDone(ok);
        checkOutput("post_abort_mode", 32'({s1, s0}), 32'd1);

        syncDrive();
        abort = 1'b1;
        syncDrive();
        abort = 1'b0;
        @(negedge clock);
        checkOutput("idle_abort_pulse", 32'(aborted), 32'd1);

        syncDrive();
        applyStimulus(2'b00, 5, w);
        repeat (4) @(posedge clock);
        #3 reset_n = 1'b0;
        #1 checkOutput("async_reset_outputs",
                       32'({s1, s0, cnt_en, cnt_clr, busy, done, aborted}), 32'd0);
        @(negedge clock);
        #1 reset_n = 1'b1;
        @(negedge clock);
        checkOutput("reset_ready", 32'(cmd_ready), 32'd1);
        checkOutput("reset_no_done", 32'(done), 32'd0);

        syncDrive();
        repeat (800) begin
            cmd_valid = ($urandom_range(0, 2) == 0);
            cmd_mode  = 2'($urandom_range(0, 3));
            cmd_steps = ($urandom_range(0, 7) == 0) ? STEP_W'($urandom_range(0, 40))
                                                    : STEP_W'($urandom_range(0, 5));
            abort     = ($urandom_range(0, 49) == 0);
            syncDrive();
        end
        cmd_valid = 1'b0;
        abort     = 1'b0;
        waitIdle();
        repeat (3) @(negedge clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
